// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: a DEPTH-entry in-order buffer with flush, freeze and bubble output.
// in_ready is decoded from occupancy and the flush/freeze controls only, never from out_ready.
module pipe_stage_buf #(
    parameter int                 DATA_W  = 32,
    parameter int                 DEPTH   = 2,
    parameter logic [DATA_W-1:0]  NOP_VAL = '0
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           in_valid,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_data,
    input  logic                           out_ready,
    input  logic                           flush,
    input  logic                           freeze,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           squashed
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_squashed;

    logic w_push;
    logic w_pop;

    // Pointers wrap explicitly so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // nRST gates in_ready so it drops immediately on reset, before any clock edge.
    assign in_ready  = nRST & (r_count < FULL_CNT) & ~freeze & ~flush;
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rptr] : NOP_VAL;
    assign count     = r_count;
    assign squashed  = r_squashed;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready & ~freeze & ~flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_squashed <= 1'b0;
        end else if (flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_squashed <= (r_count != '0);
        end else begin
            r_squashed <= 1'b0;
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: out_data is masked to NOP_VAL while empty.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wptr] <= in_data;
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (DEPTH 2, 3, 1) checked every cycle against queue models.
module tb_pipe_stage_buf;

    localparam int          DEP [3] = '{2, 3, 1};
    localparam logic [7:0]  NOP [3] = '{8'h00, 8'hEE, 8'h00};

    logic       CLK = 1'b0;
    logic       nRST;
    logic [2:0] inv, outr, fl, fz;
    logic [7:0] ind  [3];
    logic [2:0] inr, outv, sq;
    logic [7:0] outd [3];
    logic [1:0] c_d2, c_d3;
    logic [0:0] c_d1;

    int nchk = 0;
    int nerr = 0;

    logic [7:0] q0[$], q1[$], q2[$];
    bit         msq [3];

    always #5 CLK = ~CLK;

    pipe_stage_buf #(.DATA_W(8), .DEPTH(2), .NOP_VAL(8'h00)) u_d2 (
        .CLK(CLK), .nRST(nRST), .in_valid(inv[0]), .in_data(ind[0]), .in_ready(inr[0]),
        .out_valid(outv[0]), .out_data(outd[0]), .out_ready(outr[0]), .flush(fl[0]),
        .freeze(fz[0]), .count(c_d2), .squashed(sq[0]));
    pipe_stage_buf #(.DATA_W(8), .DEPTH(3), .NOP_VAL(8'hEE)) u_d3 (
        .CLK(CLK), .nRST(nRST), .in_valid(inv[1]), .in_data(ind[1]), .in_ready(inr[1]),
        .out_valid(outv[1]), .out_data(outd[1]), .out_ready(outr[1]), .flush(fl[1]),
        .freeze(fz[1]), .count(c_d3), .squashed(sq[1]));
    pipe_stage_buf #(.DATA_W(8), .DEPTH(1), .NOP_VAL(8'h00)) u_d1 (
        .CLK(CLK), .nRST(nRST), .in_valid(inv[2]), .in_data(ind[2]), .in_ready(inr[2]),
        .out_valid(outv[2]), .out_data(outd[2]), .out_ready(outr[2]), .flush(fl[2]),
        .freeze(fz[2]), .count(c_d1), .squashed(sq[2]));

    function automatic int getcnt(int i);
        case (i)
            0:       return int'(c_d2);
            1:       return int'(c_d3);
            default: return int'(c_d1);
        endcase
    endfunction

    function automatic int msize(int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [7:0] mhead(int i);
        if (msize(i) == 0) return NOP[i];
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic mpush(int i, logic [7:0] d);
        case (i)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic mpop(int i);
        case (i)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic mclr(int i);
        case (i)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s[inst%0d] observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    task automatic idle();
        inv = '0; outr = '0; fl = '0; fz = '0;
        for (int i = 0; i < 3; i++) ind[i] = 8'h00;
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after it.
    task automatic tick();
        bit rdy, push, pop;
        #1;
        for (int i = 0; i < 3; i++) begin
            rdy  = (msize(i) < DEP[i]) && !fz[i] && !fl[i];
            chk("in_ready", i, 32'(inr[i]), 32'(rdy));
            push = inv[i] && rdy;
            pop  = (msize(i) > 0) && outr[i] && !fz[i] && !fl[i];
            if (fl[i]) begin
                msq[i] = (msize(i) != 0);
                mclr(i);
            end else begin
                msq[i] = 1'b0;
                if (pop)  mpop(i);
                if (push) mpush(i, ind[i]);
            end
        end
        @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("out_valid", i, 32'(outv[i]), 32'(msize(i) != 0));
            chk("out_data",  i, 32'(outd[i]), 32'(mhead(i)));
            chk("count",     i, 32'(getcnt(i)), 32'(msize(i)));
            chk("squashed",  i, 32'(sq[i]), 32'(msq[i]));
        end
        @(negedge CLK);
    endtask

    // Asserts nRST between edges and checks the asynchronous clear before any clock.
    task automatic do_reset();
        #2;
        nRST = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", i, 32'(outv[i]), 32'd0);
            chk("rst_count",     i, 32'(getcnt(i)), 32'd0);
            chk("rst_in_ready",  i, 32'(inr[i]), 32'd0);
            chk("rst_out_data",  i, 32'(outd[i]), 32'(NOP[i]));
            mclr(i);
            msq[i] = 1'b0;
        end
        @(negedge CLK);
        @(negedge CLK);
        idle();
        #2;
        nRST = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_squashed", i, 32'(sq[i]), 32'd0);
            chk("rel_in_ready", i, 32'(inr[i]), 32'd1);
        end
        @(negedge CLK);
    endtask

    initial begin
        idle();
        nRST = 1'b1;
        @(negedge CLK);
        do_reset();

        // DEPTH=2 fill with out_ready low, then drain back-to-back
        outr[0] = 1'b0; inv[0] = 1'b1; ind[0] = 8'hA1; tick();
        ind[0] = 8'hA2; tick();
        chk("d2_full_count", 0, 32'(c_d2), 32'd2);
        chk("d2_head", 0, 32'(outd[0]), 32'hA1);
        inv[0] = 1'b0; outr[0] = 1'b1; tick();
        chk("d2_drain2", 0, 32'(outd[0]), 32'hA2);
        tick();
        chk("d2_empty_nop", 0, 32'(outd[0]), 32'h00);

        // DEPTH=3 continuous stream with pointer wrap
        idle(); outr[1] = 1'b1; inv[1] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            ind[1] = 8'(k);
            tick();
            chk("d3_stream", 1, 32'(outd[1]), 32'(k));
            chk("d3_count1", 1, 32'(c_d3), 32'd1);
        end
        inv[1] = 1'b0; tick();

        // Flush with two entries and a competing push
        idle(); inv[0] = 1'b1; ind[0] = 8'h11; tick();
        ind[0] = 8'h22; tick();
        fl[0] = 1'b1; ind[0] = 8'hFF; tick();
        chk("flush_sq", 0, 32'(sq[0]), 32'd1);
        chk("flush_nop", 0, 32'(outd[0]), 32'h00);
        fl[0] = 1'b0; inv[0] = 1'b0; outr[0] = 1'b1; tick();
        chk("flush_sq_pulse", 0, 32'(sq[0]), 32'd0);
        chk("flush_no_ff", 0, 32'(outd[0]), 32'h00);

        // Freeze holds a single entry despite push and pop requests
        idle(); inv[0] = 1'b1; ind[0] = 8'h3C; tick();
        fz[0] = 1'b1; outr[0] = 1'b1; ind[0] = 8'h4D;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("frz_count", 0, 32'(c_d2), 32'd1);
            chk("frz_data", 0, 32'(outd[0]), 32'h3C);
        end
        fz[0] = 1'b0; inv[0] = 1'b0; tick();

        // DEPTH=1 throughput: one beat every two cycles
        idle(); inv[2] = 1'b1; outr[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ind[2] = 8'(8'h60 + k);
            tick();
        end
        idle(); tick();

        // Reset mid-transfer with two entries held, then a fresh beat
        inv[0] = 1'b1; ind[0] = 8'h71; tick();
        ind[0] = 8'h72; tick();
        do_reset();
        inv[0] = 1'b1; ind[0] = 8'h55; tick();
        chk("post_rst_55", 0, 32'(outd[0]), 32'h55);
        idle(); outr[0] = 1'b1; tick();

        // Randomized traffic with occasional flush/freeze and one mid-run reset
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                inv[i]  = 1'($urandom_range(0, 1));
                outr[i] = 1'($urandom_range(0, 3) != 0);
                ind[i]  = 8'($urandom);
                fl[i]   = ($urandom_range(0, 15) == 0);
                fz[i]   = ($urandom_range(0, 7) == 0);
            end
            tick();
            if (n == 200) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
